// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one MIG p0 command port among three burst requesters; one command per grant.
// Optional DDR_ARB_STATS_EN adds saturating grant/timeout statistics outputs.
module ddr_port_arbiter #(
  parameter int BURST_LEN = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        calib_done_i,
  input  logic [2:0]  req_i,
  input  logic [2:0]  rnw_i,
  input  logic [89:0] req_addr_i,
  input  logic [2:0]  done_i,
  output logic [2:0]  gnt_o,
  input  logic        cmd_full_i,
  output logic        cmd_en_o,
  output logic [2:0]  cmd_instr_o,
  output logic [29:0] cmd_byte_addr_o,
  output logic [5:0]  cmd_bl_o,
  output logic        busy_o,
  output logic        timeout_err_o,
`ifdef DDR_ARB_STATS_EN
  output logic [47:0] grant_count_o,
  output logic [7:0]  timeout_count_o,
`endif
  input  logic        clear_err_i
);

  typedef enum logic [2:0] {IDLE, RD_CMD, DATA, WR_CMD, RELEASE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic        cmd_en_q, cmd_en_d;
  logic [1:0]  gidx_q, gidx_d;
  logic        rnw_q, rnw_d;
  logic [29:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  rr_q, rr_d;
  logic        err_q, err_d;

  logic [1:0]  cand [3];
  logic [1:0]  sel_idx;
  logic [29:0] sel_addr;
  logic        start;
  logic        done_g;
  logic        timeout_hit;

  // Search order rr, rr+1, rr+2 (mod 3); walking backwards leaves the first hit in sel_idx.
  always_comb begin
    cand[0] = rr_q;
    cand[1] = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    cand[2] = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;
    sel_idx = rr_q;
    for (int k = 2; k >= 0; k--) begin
      if (req_i[cand[k]]) sel_idx = cand[k];
    end
    case (sel_idx)
      2'd0:    sel_addr = req_addr_i[29:0];
      2'd1:    sel_addr = req_addr_i[59:30];
      default: sel_addr = req_addr_i[89:60];
    endcase
  end

  assign start       = (state_q == IDLE) && calib_done_i && (req_i != 3'b000);
  assign done_g      = done_i[gidx_q];
  assign timeout_hit = (state_q == DATA) && !done_g && (cnt_q <= 8'd1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = rnw_i[sel_idx] ? RD_CMD : DATA;
      RD_CMD:  if (!cmd_full_i) state_d = DATA;
      DATA: begin
        // A write whose command can go out immediately skips the WR_CMD stall state.
        if (done_g)           state_d = (!rnw_q && cmd_full_i) ? WR_CMD : RELEASE;
        else if (timeout_hit) state_d = RELEASE;
      end
      WR_CMD:  if (!cmd_full_i) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    cmd_en_d = 1'b0;
    gidx_d   = gidx_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    err_d    = err_q;
    if (clear_err_i) err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          gnt_d  = 3'b001 << sel_idx;
          gidx_d = sel_idx;
          rnw_d  = rnw_i[sel_idx];
          addr_d = sel_addr & ~30'h3;
          cnt_d  = 8'(TIMEOUT);
        end
      end
      RD_CMD: cmd_en_d = !cmd_full_i;
      DATA: begin
        cnt_d = cnt_q - 8'd1;
        if (done_g || timeout_hit) gnt_d = 3'b000;
        if (done_g && !rnw_q)      cmd_en_d = !cmd_full_i;
      end
      WR_CMD:  cmd_en_d = !cmd_full_i;
      RELEASE: rr_d = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gnt_q    <= 3'b000;
      cmd_en_q <= 1'b0;
      gidx_q   <= 2'd0;
      rnw_q    <= 1'b0;
      addr_q   <= 30'd0;
      cnt_q    <= 8'd0;
      rr_q     <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      cmd_en_q <= cmd_en_d;
      gidx_q   <= gidx_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign cmd_en_o        = cmd_en_q;
  assign cmd_instr_o     = {2'b00, rnw_q};
  assign cmd_byte_addr_o = addr_q;
  assign cmd_bl_o        = 6'(BURST_LEN - 1);
  assign busy_o          = (state_q != IDLE);
  assign timeout_err_o   = err_q;

`ifdef DDR_ARB_STATS_EN
  logic [15:0] gcnt_q [3];
  logic [7:0]  tcnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 3; i++) gcnt_q[i] <= 16'd0;
      tcnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (start && (sel_idx == 2'(i)) && (gcnt_q[i] != 16'hFFFF)) gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
      if (timeout_hit && (tcnt_q != 8'hFF)) tcnt_q <= tcnt_q + 8'd1;
    end
  end

  assign grant_count_o   = {gcnt_q[2], gcnt_q[1], gcnt_q[0]};
  assign timeout_count_o = tcnt_q;
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: directed scenarios plus a randomized phase scored against a transaction model.
`timescale 1ns/1ps
module tb_ddr_port_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n, calib_done, cmd_full, clear_err;
  logic [2:0]  req, rnw, done, gnt, cmd_instr;
  logic [89:0] req_addr;
  logic        cmd_en, busy, timeout_err;
  logic [29:0] cmd_byte_addr;
  logic [5:0]  cmd_bl;
`ifdef DDR_ARB_STATS_EN
  logic [47:0] grant_count;
  logic [7:0]  timeout_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.BURST_LEN(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .calib_done_i(calib_done),
    .req_i(req), .rnw_i(rnw), .req_addr_i(req_addr), .done_i(done),
    .gnt_o(gnt), .cmd_full_i(cmd_full), .cmd_en_o(cmd_en),
    .cmd_instr_o(cmd_instr), .cmd_byte_addr_o(cmd_byte_addr), .cmd_bl_o(cmd_bl),
    .busy_o(busy), .timeout_err_o(timeout_err),
`ifdef DDR_ARB_STATS_EN
    .grant_count_o(grant_count), .timeout_count_o(timeout_count),
`endif
    .clear_err_i(clear_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; req = '0; rnw = '0; done = '0; req_addr = '0;
    cmd_full = 1'b0; clear_err = 1'b0; calib_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_addr(input int i, input logic [29:0] a);
    req_addr[i*30 +: 30] = a;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Random-phase model state
  int          rr_m, gi, ph, dstart, dly, free_e, cnt, w;
  bit          act, g_rnw, err_m, exp_en, grant_now, found;
  logic [29:0] g_addr;
  logic [2:0]  exp_gnt;

  initial begin
    do_reset;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_cmd_en", cmd_en, 0);
    check_eq("rst_instr", cmd_instr, 0);
    check_eq("rst_addr", cmd_byte_addr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", timeout_err, 0);
    check_eq("cmd_bl", cmd_bl, 31);

    // Read by requester 1
    req = 3'b010; rnw = 3'b010; set_addr(1, 30'h103);
    tick;
    check_eq("t1_gnt", gnt, 3'b010);
    check_eq("t1_no_en_yet", cmd_en, 0);
    req = 3'b000;
    tick;
    check_eq("t1_cmd_en", cmd_en, 1);
    check_eq("t1_instr", cmd_instr, 3'b001);
    check_eq("t1_addr", cmd_byte_addr, 30'h100);
    done = 3'b010;
    tick;
    done = 3'b000;
    check_eq("t1_gnt_rel", gnt, 0);
    check_eq("t1_busy_rel", busy, 1);
    tick;
    check_eq("t1_idle", busy, 0);

    // Write by requester 0
    req = 3'b001; rnw = 3'b000; set_addr(0, 30'h80);
    tick;
    check_eq("t2_gnt", gnt, 3'b001);
    req = 3'b000;
    cnt = 0;
    repeat (3) begin tick; cnt += int'(cmd_en); end
    check_eq("t2_no_en_before_done", cnt, 0);
    done = 3'b001;
    tick;
    done = 3'b000;
    check_eq("t2_cmd_en", cmd_en, 1);
    check_eq("t2_instr", cmd_instr, 3'b000);
    check_eq("t2_addr", cmd_byte_addr, 30'h80);
    check_eq("t2_gnt_rel", gnt, 0);
    tick;
    check_eq("t2_en_pulse", cmd_en, 0);
    check_eq("t2_idle", busy, 0);

    // Round-robin with all three requesting
    do_reset;
    req = 3'b111; rnw = 3'b000; set_addr(0, 30'h10); set_addr(1, 30'h20); set_addr(2, 30'h30);
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (gnt == 3'b000 && w < 20) begin tick; w++; end
      check_eq($sformatf("t3_order%0d", k), gnt, 3'b001 << (k % 3));
      done = gnt;
      tick;
      done = 3'b000;
    end
    req = 3'b000;
    repeat (3) tick;

    // cmd_full stall in RD_CMD
    cmd_full = 1'b1;
    req = 3'b100; rnw = 3'b100; set_addr(2, 30'h2ABCDEF7);
    tick;
    check_eq("t4_gnt", gnt, 3'b100);
    req = 3'b000;
    cnt = 0;
    repeat (10) begin tick; cnt += int'(cmd_en); end
    check_eq("t4_stall", cnt, 0);
    cmd_full = 1'b0;
    tick;
    check_eq("t4_cmd_en", cmd_en, 1);
    check_eq("t4_addr", cmd_byte_addr, 30'h2ABCDEF4);
    cnt = 0;
    repeat (4) begin tick; cnt += int'(cmd_en); end
    check_eq("t4_single_pulse", cnt, 0);
    done = 3'b100;
    tick;
    done = 3'b000;
    tick;

    // Timeout on a write
    req = 3'b001; rnw = 3'b000; set_addr(0, 30'h40);
    tick;
    check_eq("t5_gnt", gnt, 3'b001);
    req = 3'b000;
    cnt = 0;
    repeat (TMO - 1) begin tick; cnt += int'(cmd_en); end
    check_eq("t5_err_early", timeout_err, 0);
    check_eq("t5_gnt_held", gnt, 3'b001);
    tick;
    cnt += int'(cmd_en);
    check_eq("t5_err_set", timeout_err, 1);
    check_eq("t5_gnt_rel", gnt, 0);
    tick;
    cnt += int'(cmd_en);
    check_eq("t5_no_cmd", cnt, 0);
    check_eq("t5_idle", busy, 0);
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    check_eq("t5_cleared", timeout_err, 0);

    // Timeout with clear_err held: set wins on the timeout cycle
    req = 3'b010; rnw = 3'b000; clear_err = 1'b1;
    tick;
    req = 3'b000;
    repeat (TMO) tick;
    check_eq("t5_set_wins", timeout_err, 1);
    tick;
    check_eq("t5_clear_after", timeout_err, 0);
    clear_err = 1'b0;
    tick;

    // Asynchronous reset mid-DATA, then calib_done low holds off grants
    req = 3'b100; rnw = 3'b000;
    tick;
    req = 3'b000;
    repeat (2) tick;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_gnt_async", gnt, 0);
    check_eq("t6_en_async", cmd_en, 0);
    check_eq("t6_busy_async", busy, 0);
    calib_done = 1'b0;
    req = 3'b111;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin tick; cnt += int'(gnt != 3'b000); end
    check_eq("t6_no_grant_uncal", cnt, 0);
    check_eq("t6_idle_uncal", busy, 0);
    calib_done = 1'b1;
    tick;
    check_eq("t6_grant_after_cal", gnt, 3'b001);

    // Randomized phase
    do_reset;
    rr_m = 0; act = 0; free_e = 0; err_m = 0; gi = 0; ph = 0; dstart = 0; dly = 1;
    g_rnw = 0; g_addr = '0;
    for (int e = 0; e < 3000; e++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && !(act && gi == i) && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          rnw[i] = 1'($urandom_range(1));
          req_addr[i*30 +: 30] = 30'($urandom);
        end
      end
      cmd_full   = ($urandom_range(3) == 0);
      calib_done = ($urandom_range(15) != 0);
      clear_err  = ($urandom_range(31) == 0);
      done = 3'b000;
      if (act && ph == 1 && (e - dstart + 1) == dly) done[gi] = 1'b1;
      if ($urandom_range(7) == 0) begin
        int j;
        j = int'($urandom_range(2));
        if (!(act && j == gi)) done[j] = 1'b1;
      end

      exp_en = 0; grant_now = 0;
      if (clear_err) err_m = 0;
      if (!act) begin
        if (e >= free_e && calib_done && req != 3'b000) begin
          found = 0;
          for (int k = 0; k < 3; k++) begin
            if (!found && req[(rr_m + k) % 3]) begin gi = (rr_m + k) % 3; found = 1; end
          end
          act = 1; grant_now = 1;
          g_rnw = rnw[gi];
          g_addr = req_addr[gi*30 +: 30] & ~30'h3;
          ph = g_rnw ? 0 : 1;
          dstart = e + 1;
          dly = int'($urandom_range(TMO + 3, 1));
        end
      end else begin
        case (ph)
          0: if (!cmd_full) begin exp_en = 1; ph = 1; dstart = e + 1; end
          1: begin
            if (done[gi]) begin
              if (g_rnw || !cmd_full) begin
                exp_en = !g_rnw; act = 0; free_e = e + 2; rr_m = (gi + 1) % 3;
              end else ph = 2;
            end else if (e - dstart + 1 == TMO) begin
              err_m = 1; act = 0; free_e = e + 2; rr_m = (gi + 1) % 3;
            end
          end
          default: if (!cmd_full) begin exp_en = 1; act = 0; free_e = e + 2; rr_m = (gi + 1) % 3; end
        endcase
      end
      exp_gnt = (act && ph != 2) ? 3'(3'b001 << gi) : 3'b000;

      tick;
      check_eq("r_gnt", gnt, exp_gnt);
      check_eq("r_cmd_en", cmd_en, exp_en);
      if (exp_en) begin
        check_eq("r_instr", cmd_instr, {2'b00, g_rnw});
        check_eq("r_addr", cmd_byte_addr, g_addr);
      end
      check_eq("r_busy", busy, act || (e + 1 < free_e));
      check_eq("r_err", timeout_err, err_m);
      if (grant_now) req[gi] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
